// File: rtl/multicycle_ctrl_if.sv
// Memory request/acknowledge bundle between the multicycle controller and the
// memory port. The controller is the master (issues mem_req/mem_we); the memory
// side is the slave (returns mem_ready).
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic mem_ready;

    modport master (output mem_req, output mem_we, input mem_ready);
    modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for an RV32I core: sequences the shared ALU, memory
// port and register file through fetch/decode/execute/memory/writeback.
// Strobes are a Moore decode of the registered state, forced to 0 while rst is
// high. ir_write/pc_write in FETCH are qualified by the memory handshake, and
// pc_write in BEQ follows the ALU zero flag.
// Optional feature: define CTRL_PERF_CNT_EN to build the cycle/instret counters;
// without it both counter ports read 0 and no counter flops exist.
module multicycle_ctrl #(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic                 zero,
    multicycle_ctrl_if.master    mem,
    output logic                 adr_src,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic [1:0]           result_src,
    output logic [2:0]           imm_src,
    output logic                 trap,
    output logic [CNT_W-1:0]     cycle_cnt,
    output logic [CNT_W-1:0]     instret_cnt
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam int TCNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TCNT_W-1:0] TMAX = TCNT_W'(TIMEOUT_CYC);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
        S_EXEC_R, S_EXEC_I, S_ALU_WB, S_JAL, S_BEQ, S_TRAP
    } state_t;

    state_t            state_q, state_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic [TCNT_W-1:0] tcnt_inc;
    logic              trap_q, trap_d;

    // Moore strobes of the current state (before reset masking)
    logic       req_m, we_m, adr_m, regw_m, jal_m, beq_m;
    logic [1:0] srca_m, srcb_m, aluop_m, res_m;
    logic [2:0] imm_m;
    logic       handshake, waiting;

    // Moore decode of the registered state into datapath strobes
    always_comb begin
        req_m   = 1'b0;
        we_m    = 1'b0;
        adr_m   = 1'b0;
        regw_m  = 1'b0;
        jal_m   = 1'b0;
        beq_m   = 1'b0;
        srca_m  = 2'b00;
        srcb_m  = 2'b00;
        aluop_m = 2'b00;
        res_m   = 2'b00;
        imm_m   = 3'b000;
        case (state_q)
            S_FETCH:   begin req_m = 1'b1; srcb_m = 2'b10; end
            S_DECODE:  begin srca_m = 2'b01; srcb_m = 2'b01; imm_m = 3'b010; end
            S_MEM_ADR: begin
                srca_m = 2'b10;
                srcb_m = 2'b01;
                imm_m  = (opcode == OP_STORE) ? 3'b001 : 3'b000;
            end
            S_MEM_RD:  begin req_m = 1'b1; adr_m = 1'b1; end
            S_MEM_WB:  begin regw_m = 1'b1; res_m = 2'b01; end
            S_MEM_WR:  begin req_m = 1'b1; we_m = 1'b1; adr_m = 1'b1; end
            S_EXEC_R:  begin srca_m = 2'b10; aluop_m = 2'b10; end
            S_EXEC_I:  begin srca_m = 2'b10; srcb_m = 2'b01; aluop_m = 2'b10; end
            S_ALU_WB:  begin regw_m = 1'b1; end
            S_JAL:     begin
                srca_m = 2'b01;
                srcb_m = 2'b10;
                imm_m  = 3'b011;
                regw_m = 1'b1;
                jal_m  = 1'b1;
            end
            S_BEQ:     begin srca_m = 2'b10; aluop_m = 2'b01; beq_m = 1'b1; end
            default:   ;
        endcase
        handshake = req_m & mem.mem_ready;
        waiting   = req_m & ~mem.mem_ready;
    end

    // Next-state, memory-wait timeout and sticky trap
    always_comb begin
        state_d  = state_q;
        tcnt_d   = '0;
        tcnt_inc = tcnt_q + 1'b1;
        case (state_q)
            S_FETCH:   if (handshake) state_d = S_DECODE;
            S_DECODE:  begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_JAL:            state_d = S_JAL;
                    OP_BEQ:            state_d = S_BEQ;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEM_ADR: state_d = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:  if (handshake) state_d = S_MEM_WB;
            S_MEM_WB:  state_d = S_FETCH;
            S_MEM_WR:  if (handshake) state_d = S_FETCH;
            S_EXEC_R:  state_d = S_ALU_WB;
            S_EXEC_I:  state_d = S_ALU_WB;
            S_ALU_WB:  state_d = S_FETCH;
            S_JAL:     state_d = S_FETCH;
            S_BEQ:     state_d = S_FETCH;
            default:   state_d = S_TRAP;
        endcase
        // A waiting request never changes state, so the count only survives
        // while the same access stays unacknowledged.
        if ((TIMEOUT_CYC > 0) && waiting) begin
            tcnt_d = tcnt_inc;
            if (tcnt_inc == TMAX) state_d = S_TRAP;
        end
        trap_d = trap_q | (state_d == S_TRAP);
    end

    // State, timeout counter and trap flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            tcnt_q  <= '0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            trap_q  <= trap_d;
        end
    end

    // Output strobes, all held low while reset is asserted
    always_comb begin
        mem.mem_req = ~rst & req_m;
        mem.mem_we  = ~rst & we_m;
        adr_src     = ~rst & adr_m;
        reg_write   = ~rst & regw_m;
        ir_write    = ~rst & (state_q == S_FETCH) & handshake;
        pc_write    = ~rst & (((state_q == S_FETCH) & handshake) | jal_m | (beq_m & zero));
        alu_src_a   = rst ? 2'b00 : srca_m;
        alu_src_b   = rst ? 2'b00 : srcb_m;
        alu_op      = rst ? 2'b00 : aluop_m;
        result_src  = rst ? 2'b00 : res_m;
        imm_src     = rst ? 3'b000 : imm_m;
        trap        = ~rst & trap_q;
    end

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             retire;

    // Retirement is any return to FETCH from an execute-side state
    always_comb begin
        retire    = (state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_TRAP);
        cycle_d   = cycle_q + 1'b1;
        instret_d = retire ? instret_q + 1'b1 : instret_q;
    end

    // Performance counters, wrapping modulo 2^CNT_W
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each stimulus cycle pushes the expected
// strobe vector; a negedge monitor pops and compares against the DUT.
module tb_multicycle_ctrl;
    localparam int CNT_W = 32;

    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] BAD = 7'b1111111;

    // {req, we, adr, ir_w, pc_w, reg_w, src_a, src_b, alu_op, res_src, imm_src, trap}
    localparam logic [17:0] E_RST    = 18'b0_0_0_0_0_0_00_00_00_00_000_0;
    localparam logic [17:0] E_FWAIT  = 18'b1_0_0_0_0_0_00_10_00_00_000_0;
    localparam logic [17:0] E_FACK   = 18'b1_0_0_1_1_0_00_10_00_00_000_0;
    localparam logic [17:0] E_DEC    = 18'b0_0_0_0_0_0_01_01_00_00_010_0;
    localparam logic [17:0] E_ADR_LD = 18'b0_0_0_0_0_0_10_01_00_00_000_0;
    localparam logic [17:0] E_ADR_ST = 18'b0_0_0_0_0_0_10_01_00_00_001_0;
    localparam logic [17:0] E_MRD    = 18'b1_0_1_0_0_0_00_00_00_00_000_0;
    localparam logic [17:0] E_MWB    = 18'b0_0_0_0_0_1_00_00_00_01_000_0;
    localparam logic [17:0] E_MWR    = 18'b1_1_1_0_0_0_00_00_00_00_000_0;
    localparam logic [17:0] E_EXR    = 18'b0_0_0_0_0_0_10_00_10_00_000_0;
    localparam logic [17:0] E_EXI    = 18'b0_0_0_0_0_0_10_01_10_00_000_0;
    localparam logic [17:0] E_AWB    = 18'b0_0_0_0_0_1_00_00_00_00_000_0;
    localparam logic [17:0] E_JAL    = 18'b0_0_0_0_1_1_01_10_00_00_011_0;
    localparam logic [17:0] E_BEQ1   = 18'b0_0_0_0_1_0_10_00_01_00_000_0;
    localparam logic [17:0] E_BEQ0   = 18'b0_0_0_0_0_0_10_00_01_00_000_0;
    localparam logic [17:0] E_TRAP   = 18'b0_0_0_0_0_0_00_00_00_00_000_1;

    logic             clk = 1'b0;
    logic             rst;
    logic [6:0]       opcode;
    logic             zero;
    logic             adr_src, ir_write, pc_write, reg_write, trap;
    logic [1:0]       alu_src_a, alu_src_b, alu_op, result_src;
    logic [2:0]       imm_src;
    logic [CNT_W-1:0] cycle_cnt, instret_cnt;
    logic [17:0]      act;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [17:0] exp;
        string       name;
    } sb_t;
    sb_t sb[$];

    multicycle_ctrl_if mem_bus();

    multicycle_ctrl #(.TIMEOUT_CYC(16), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .zero        (zero),
        .mem         (mem_bus.master),
        .adr_src     (adr_src),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .result_src  (result_src),
        .imm_src     (imm_src),
        .trap        (trap),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

    always #5 clk = ~clk;

    assign act = {mem_bus.mem_req, mem_bus.mem_we, adr_src, ir_write, pc_write, reg_write,
                  alu_src_a, alu_src_b, alu_op, result_src, imm_src, trap};

    // Monitor: pop one expectation per presented cycle and compare
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            sb_t item;
            item = sb.pop_front();
            n_tests++;
            if (act !== item.exp) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", item.name, act, item.exp);
            end
        end
    end

    // One clock of stimulus; expectation covers the cycle just driven
    task automatic step(input logic r, input logic rdy, input logic z,
                        input logic [6:0] op, input logic [17:0] e, input string nm);
        sb_t item;
        rst               = r;
        mem_bus.mem_ready = rdy;
        zero              = z;
        opcode            = op;
        item.exp          = e;
        item.name         = nm;
        sb.push_back(item);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1, 1'b0, 7'b0, E_RST, "reset");
        step(1'b1, 1'b0, 1'b0, 7'b0, E_RST, "reset");
    endtask

    initial begin
        rst               = 1'b1;
        mem_bus.mem_ready = 1'b0;
        zero              = 1'b0;
        opcode            = 7'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Three single-issue ALU instructions (R, I, R)
        step(0, 1, 0, RT, E_FACK, "r_fetch");
        step(0, 1, 0, RT, E_DEC,  "r_decode");
        step(0, 1, 0, RT, E_EXR,  "r_exec");
        step(0, 1, 0, RT, E_AWB,  "r_wb");
        step(0, 1, 0, IT, E_FACK, "i_fetch");
        step(0, 1, 0, IT, E_DEC,  "i_decode");
        step(0, 1, 0, IT, E_EXI,  "i_exec");
        step(0, 1, 0, IT, E_AWB,  "i_wb");
        step(0, 1, 0, RT, E_FACK, "r2_fetch");
        step(0, 1, 0, RT, E_DEC,  "r2_decode");
        step(0, 1, 0, RT, E_EXR,  "r2_exec");
        step(0, 1, 0, RT, E_AWB,  "r2_wb");

`ifdef CTRL_PERF_CNT_EN
        n_tests++;
        if (instret_cnt !== 32'd3) begin
            n_fail++;
            $display("FAIL instret_cnt: got %0d expected 3", instret_cnt);
        end
        n_tests++;
        if (cycle_cnt !== 32'd12) begin
            n_fail++;
            $display("FAIL cycle_cnt: got %0d expected 12", cycle_cnt);
        end
`endif

        // Load with 3 wait cycles in MEM_RD: 8 cycles total
        step(0, 1, 0, LD, E_FACK,   "ld_fetch");
        step(0, 1, 0, LD, E_DEC,    "ld_decode");
        step(0, 1, 0, LD, E_ADR_LD, "ld_adr");
        step(0, 0, 0, LD, E_MRD,    "ld_rd_wait1");
        step(0, 0, 0, LD, E_MRD,    "ld_rd_wait2");
        step(0, 0, 0, LD, E_MRD,    "ld_rd_wait3");
        step(0, 1, 0, LD, E_MRD,    "ld_rd_ack");
        step(0, 1, 0, LD, E_MWB,    "ld_wb");

        // Store, no wait
        step(0, 1, 0, ST, E_FACK,   "st_fetch");
        step(0, 1, 0, ST, E_DEC,    "st_decode");
        step(0, 1, 0, ST, E_ADR_ST, "st_adr");
        step(0, 1, 0, ST, E_MWR,    "st_wr");

        // JAL
        step(0, 1, 0, JL, E_FACK, "jal_fetch");
        step(0, 1, 0, JL, E_DEC,  "jal_decode");
        step(0, 1, 0, JL, E_JAL,  "jal_exec");

        // BEQ taken then not taken
        step(0, 1, 1, BQ, E_FACK, "beq1_fetch");
        step(0, 1, 1, BQ, E_DEC,  "beq1_decode");
        step(0, 1, 1, BQ, E_BEQ1, "beq_taken");
        step(0, 1, 0, BQ, E_FACK, "beq0_fetch");
        step(0, 1, 0, BQ, E_DEC,  "beq0_decode");
        step(0, 1, 0, BQ, E_BEQ0, "beq_not_taken");

        // Fetch wait: strobes gated until mem_ready
        step(0, 0, 0, RT, E_FWAIT, "fetch_wait1");
        step(0, 0, 0, RT, E_FWAIT, "fetch_wait2");
        step(0, 1, 0, RT, E_FACK,  "fetch_ack");
        step(0, 1, 0, RT, E_DEC,   "fw_decode");
        step(0, 1, 0, RT, E_EXR,   "fw_exec");
        step(0, 1, 0, RT, E_AWB,   "fw_wb");

        // Reset mid-store: back to FETCH with mem_we dropped
        step(0, 1, 0, ST, E_FACK,   "rs_fetch");
        step(0, 1, 0, ST, E_DEC,    "rs_decode");
        step(0, 1, 0, ST, E_ADR_ST, "rs_adr");
        step(0, 0, 0, ST, E_MWR,    "rs_wr_wait");
        step(1, 1, 0, ST, E_RST,    "rs_in_reset");
        step(0, 0, 0, ST, E_FWAIT,  "rs_after_fetch");
        step(0, 1, 0, RT, E_FACK,   "rs_refetch");
        step(0, 1, 0, RT, E_DEC,    "rs_decode2");
        step(0, 1, 0, RT, E_EXR,    "rs_exec2");
        step(0, 1, 0, RT, E_AWB,    "rs_wb2");

        // Illegal opcode: TRAP held 20 cycles until reset
        step(0, 1, 0, BAD, E_FACK, "ill_fetch");
        step(0, 1, 0, BAD, E_DEC,  "ill_decode");
        for (int i = 0; i < 20; i++)
            step(0, logic'(i % 2), logic'(i % 3 == 0), BAD, E_TRAP, "ill_trap");
        do_reset();

        // Memory timeout: 16 unacknowledged fetch cycles, TRAP on the 17th
        for (int i = 0; i < 16; i++)
            step(0, 0, 0, RT, E_FWAIT, "to_wait");
        step(0, 1, 0, RT, E_TRAP, "to_trap17");
        step(0, 1, 0, RT, E_TRAP, "to_trap18");
        do_reset();

        // Recovery after reset
        step(0, 1, 0, RT, E_FACK, "post_fetch");
        step(0, 1, 0, RT, E_DEC,  "post_decode");
        step(0, 1, 0, RT, E_EXR,  "post_exec");
        step(0, 1, 0, RT, E_AWB,  "post_wb");
        step(0, 0, 0, RT, E_FWAIT, "post_fetch2");

        @(negedge clk);
        #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
